// File: rtl/chip_gate_tester.sv
// Exhaustive tester for 74xx-style multi-gate chips: one vector drives every gate, then outputs are checked.
// Define CHIP_TESTER_ERR_CAPTURE_EN to add first-failure capture outputs (Err_Valid/Err_Vec/Err_Gate).
module chip_gate_tester #(
  parameter int NUM_GATES     = 3,
  parameter int NUM_INPUTS    = 3,
  parameter int GATE_FUNC     = 3,
  parameter int SETTLE_CYCLES = 2,
  localparam int ERR_W        = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            Run,
  input  logic                            DISP_RSLT,
  output logic [NUM_GATES*NUM_INPUTS-1:0] Gate_In,
  input  logic [NUM_GATES-1:0]            Gate_Out,
  output logic                            Done,
  output logic                            RSLT,
  output logic [NUM_GATES-1:0]            Fail_Mask
`ifdef CHIP_TESTER_ERR_CAPTURE_EN
  ,
  output logic                            Err_Valid,
  output logic [NUM_INPUTS-1:0]           Err_Vec,
  output logic [ERR_W-1:0]                Err_Gate
`endif
);

  typedef enum logic [2:0] {
    HALTED = 3'd0,
    SET    = 3'd1,
    DRIVE  = 3'd2,
    SETTLE = 3'd3,
    SAMPLE = 3'd4,
    DONE_S = 3'd5
  } state_t;

  state_t                            state_q, state_d;
  logic [NUM_INPUTS-1:0]             vec_q, vec_d;
  logic [7:0]                        cnt_q, cnt_d;
  logic [NUM_GATES*NUM_INPUTS-1:0]   gateIn_q, gateIn_d;
  logic                              done_q, done_d;
  logic                              rslt_q, rslt_d;
  logic [NUM_GATES-1:0]              failMask_q, failMask_d;
  logic                              expBit;
  logic [NUM_GATES-1:0]              mismatch;

  always_comb begin
    case (GATE_FUNC)
      0:       expBit = &vec_q;
      1:       expBit = |vec_q;
      2:       expBit = ~&vec_q;
      4:       expBit = ^vec_q;
      5:       expBit = ~^vec_q;
      default: expBit = ~|vec_q;
    endcase
  end

  // Gate_Out is compared raw; the settle window is what absorbs chip propagation.
  assign mismatch = Gate_Out ^ {NUM_GATES{expBit}};

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    gateIn_d   = gateIn_q;
    rslt_d     = rslt_q;
    failMask_d = failMask_q;
    case (state_q)
      HALTED: begin
        gateIn_d = '0;
        if (Run) state_d = SET;
      end
      SET: begin
        vec_d      = '0;
        failMask_d = '0;
        rslt_d     = 1'b0;
        gateIn_d   = '0;
        state_d    = DRIVE;
      end
      DRIVE: begin
        cnt_d   = 8'(SETTLE_CYCLES);
        state_d = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
      end
      SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = SAMPLE;
      end
      SAMPLE: begin
        failMask_d = failMask_q | mismatch;
        // Terminal test on all-ones so the vector counter never needs to wrap.
        if (&vec_q) begin
          rslt_d   = ~|(failMask_q | mismatch);
          gateIn_d = '0;
          state_d  = DONE_S;
        end else begin
          vec_d    = vec_q + 1'b1;
          gateIn_d = {NUM_GATES{vec_d}};
          state_d  = DRIVE;
        end
      end
      DONE_S: begin
        gateIn_d = '0;
        if (DISP_RSLT) state_d = HALTED;
      end
      default: begin
        gateIn_d = '0;
        state_d  = HALTED;
      end
    endcase
    done_d = (state_d == DONE_S);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= HALTED;
      vec_q      <= '0;
      cnt_q      <= '0;
      gateIn_q   <= '0;
      done_q     <= 1'b0;
      rslt_q     <= 1'b0;
      failMask_q <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      gateIn_q   <= gateIn_d;
      done_q     <= done_d;
      rslt_q     <= rslt_d;
      failMask_q <= failMask_d;
    end
  end

  assign Gate_In   = gateIn_q;
  assign Done      = done_q;
  assign RSLT      = rslt_q;
  assign Fail_Mask = failMask_q;

`ifdef CHIP_TESTER_ERR_CAPTURE_EN
  logic                  errValid_q, errValid_d;
  logic [NUM_INPUTS-1:0] errVec_q, errVec_d;
  logic [ERR_W-1:0]      errGate_q, errGate_d;
  logic [ERR_W-1:0]      lowFail;

  // Descending scan so the lowest failing gate index is the one left standing.
  always_comb begin
    lowFail = '0;
    for (int g = NUM_GATES - 1; g >= 0; g--) begin
      if (mismatch[g]) lowFail = ERR_W'(g);
    end
  end

  always_comb begin
    errValid_d = errValid_q;
    errVec_d   = errVec_q;
    errGate_d  = errGate_q;
    if (state_q == SET) begin
      errValid_d = 1'b0;
      errVec_d   = '0;
      errGate_d  = '0;
    end else if (state_q == SAMPLE && (|mismatch) && !errValid_q) begin
      errValid_d = 1'b1;
      errVec_d   = vec_q;
      errGate_d  = lowFail;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      errValid_q <= 1'b0;
      errVec_q   <= '0;
      errGate_q  <= '0;
    end else begin
      errValid_q <= errValid_d;
      errVec_q   <= errVec_d;
      errGate_q  <= errGate_d;
    end
  end

  assign Err_Valid = errValid_q;
  assign Err_Vec   = errVec_q;
  assign Err_Gate  = errGate_q;
`endif

endmodule

// File: tb/tb_chip_gate_tester.sv
// Directed bench for chip_gate_tester: three instances (3-in NOR default, 2-in NAND, 3-in XOR)
// each wired to a behavioural gate model with optional fault injection.
module tb_chip_gate_tester;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] run;
  logic [2:0] disp;
  logic [2:0] stuck0;

  logic [8:0] gateIn0;
  logic [2:0] gateOut0;
  logic       done0, rslt0;
  logic [2:0] failMask0;

  logic [7:0] gateIn1;
  logic [3:0] gateOut1;
  logic       done1, rslt1;
  logic [3:0] failMask1;

  logic [8:0] gateIn2;
  logic [2:0] gateOut2;
  logic       done2, rslt2;
  logic [2:0] failMask2;

  logic [2:0] doneVec;

  int nAssert = 0;
  int nFail   = 0;
  int edges;
  int found;

`ifdef CHIP_TESTER_ERR_CAPTURE_EN
  logic       errValid0, errValid1, errValid2;
  logic [2:0] errVec0, errVec2;
  logic [1:0] errVec1;
  logic [1:0] errGate0, errGate1, errGate2;
`endif

  always #5 clk = ~clk;

  chip_gate_tester dut0 (
    .Clk(clk), .Reset(reset), .Run(run[0]), .DISP_RSLT(disp[0]),
    .Gate_In(gateIn0), .Gate_Out(gateOut0), .Done(done0), .RSLT(rslt0), .Fail_Mask(failMask0)
`ifdef CHIP_TESTER_ERR_CAPTURE_EN
    , .Err_Valid(errValid0), .Err_Vec(errVec0), .Err_Gate(errGate0)
`endif
  );

  chip_gate_tester #(.NUM_GATES(4), .NUM_INPUTS(2), .GATE_FUNC(2), .SETTLE_CYCLES(0)) dut1 (
    .Clk(clk), .Reset(reset), .Run(run[1]), .DISP_RSLT(disp[1]),
    .Gate_In(gateIn1), .Gate_Out(gateOut1), .Done(done1), .RSLT(rslt1), .Fail_Mask(failMask1)
`ifdef CHIP_TESTER_ERR_CAPTURE_EN
    , .Err_Valid(errValid1), .Err_Vec(errVec1), .Err_Gate(errGate1)
`endif
  );

  chip_gate_tester #(.GATE_FUNC(4)) dut2 (
    .Clk(clk), .Reset(reset), .Run(run[2]), .DISP_RSLT(disp[2]),
    .Gate_In(gateIn2), .Gate_Out(gateOut2), .Done(done2), .RSLT(rslt2), .Fail_Mask(failMask2)
`ifdef CHIP_TESTER_ERR_CAPTURE_EN
    , .Err_Valid(errValid2), .Err_Vec(errVec2), .Err_Gate(errGate2)
`endif
  );

  // Behavioural chip models; dut2's model is deliberately wrong only on input 111.
  always_comb begin
    for (int g = 0; g < 3; g++) begin
      gateOut0[g] = stuck0[g] ? 1'b0 : ~|gateIn0[g*3 +: 3];
      gateOut2[g] = (^gateIn2[g*3 +: 3]) ^ (gateIn2[g*3 +: 3] == 3'b111);
    end
    for (int g = 0; g < 4; g++) begin
      gateOut1[g] = ~&gateIn1[g*2 +: 2];
    end
  end

  assign doneVec = {done2, done1, done0};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses Run for one edge and returns how many edges later Done was seen (-1 on timeout).
  task automatic applyStimulus(input int idx, output int nEdges);
    @(negedge clk);
    run[idx] = 1'b1;
    @(posedge clk);
    #1;
    run[idx] = 1'b0;
    nEdges = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (doneVec[idx]) begin
        nEdges = n;
        break;
      end
    end
  endtask

  task automatic ackDone(input int idx);
    @(negedge clk);
    disp[idx] = 1'b1;
    @(posedge clk);
    #1;
    disp[idx] = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    run    = '0;
    disp   = '0;
    stuck0 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_gate_in", gateIn0, '0);
    checkOutput("reset_done", done0, '0);
    checkOutput("reset_rslt", rslt0, '0);
    checkOutput("reset_fail_mask", failMask0, '0);
`ifdef CHIP_TESTER_ERR_CAPTURE_EN
    checkOutput("reset_err_valid", errValid0, '0);
`endif
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] test 1: good NOR chip");
    applyStimulus(0, edges);
    checkOutput("t1_latency", edges, 33);
    checkOutput("t1_rslt", rslt0, 1);
    checkOutput("t1_fail_mask", failMask0, 3'b000);
    checkOutput("t1_gate_in_done", gateIn0, '0);

    $display("[TB] test 5: Done_s holds until DISP_RSLT");
    @(negedge clk);
    run[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t5_done_hold", done0, 1);
      checkOutput("t5_rslt_hold", rslt0, 1);
    end
    @(negedge clk);
    disp[0] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_done_released", done0, 0);
    checkOutput("t5_rslt_in_halted", rslt0, 1);
    @(negedge clk);
    run[0]  = 1'b0;
    disp[0] = 1'b0;

    $display("[TB] test 2: gate 1 stuck low");
    stuck0 = 3'b010;
    applyStimulus(0, edges);
    checkOutput("t2_latency", edges, 33);
    checkOutput("t2_rslt", rslt0, 0);
    checkOutput("t2_fail_mask", failMask0, 3'b010);
`ifdef CHIP_TESTER_ERR_CAPTURE_EN
    checkOutput("t2_err_valid", errValid0, 1);
    checkOutput("t2_err_vec", errVec0, 3'b000);
    checkOutput("t2_err_gate", errGate0, 1);
`endif
    ackDone(0);
    checkOutput("t2_fail_mask_halted", failMask0, 3'b010);
    stuck0 = 3'b000;

    $display("[TB] test 4: reset during settle");
    @(negedge clk);
    run[0] = 1'b1;
    @(posedge clk);
    #1;
    run[0] = 1'b0;
    found = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (gateIn0 == 9'b101_101_101) begin
        found = 1;
        break;
      end
    end
    checkOutput("t4_reached_vec5", found, 1);
    checkOutput("t4_fail_mask_before", failMask0, 3'b000);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t4_gate_in_reset", gateIn0, '0);
    checkOutput("t4_done_reset", done0, 0);
    checkOutput("t4_rslt_reset", rslt0, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, edges);
    checkOutput("t4_restart_latency", edges, 33);
    checkOutput("t4_restart_rslt", rslt0, 1);
    ackDone(0);

    $display("[TB] test 3: 4x 2-in NAND, no settle");
    applyStimulus(1, edges);
    checkOutput("t3_latency", edges, 9);
    checkOutput("t3_rslt", rslt1, 1);
    checkOutput("t3_fail_mask", failMask1, 4'b0000);
    ackDone(1);

    $display("[TB] test 6: XOR chip wrong on 111");
    applyStimulus(2, edges);
    checkOutput("t6_latency", edges, 33);
    checkOutput("t6_rslt", rslt2, 0);
    checkOutput("t6_fail_mask", failMask2, 3'b111);
`ifdef CHIP_TESTER_ERR_CAPTURE_EN
    checkOutput("t6_err_valid", errValid2, 1);
    checkOutput("t6_err_vec", errVec2, 3'b111);
    checkOutput("t6_err_gate", errGate2, 0);
`endif
    ackDone(2);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
